// File: rtl/mem_requester.sv
// Single-outstanding RAM requester; store resp at accept+2, load at accept+READ_LATENCY+2, held until resp_ready.
// Optional MEM_REQUESTER_BOUNDS_CHECK_EN rejects addresses >= MEM_DEPTH with resp_err and no RAM access.
module mem_requester #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1,
  parameter int MEM_DEPTH    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  typedef enum logic [2:0] {IDLE, WR, RD, CAP, RESP} state_t;

  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

  state_t     state, state_nxt;
  logic [1:0] lat_cnt;
  logic       accept;
  logic       oob;

  assign accept = req_valid && (state == IDLE);

`ifdef MEM_REQUESTER_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  logic err_q;

  assign oob      = ({1'b0, req_addr} >= DEPTH_LIM);
  assign resp_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= oob;
    end else if (state == RESP && resp_ready) begin
      err_q <= 1'b0;
    end
  end
`else
  logic [31:0] unused_mem_depth;

  assign unused_mem_depth = 32'(MEM_DEPTH);
  assign oob              = 1'b0;
  assign resp_err         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (oob)            state_nxt = RESP;
          else if (req_write) state_nxt = WR;
          else                state_nxt = RD;
        end
      end
      WR:      state_nxt = RESP;
      RD:      if (lat_cnt == 2'd0) state_nxt = CAP;
      CAP:     state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Address/data latch at accept and hold afterwards; rdata cleared so stores and rejects return 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr    <= '0;
      ram_data_in <= '0;
      resp_rdata  <= '0;
      lat_cnt     <= '0;
    end else begin
      if (accept) begin
        ram_addr    <= req_addr;
        ram_data_in <= req_wdata;
        resp_rdata  <= '0;
        lat_cnt     <= LAT_INIT;
      end
      if (state == RD && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
      if (state == CAP) resp_rdata <= ram_data_out;
    end
  end

  // Strobes decode from state alone, so we and oe are mutually exclusive by construction.
  always_comb begin
    ram_cs = 1'b0;
    ram_we = 1'b0;
    ram_oe = 1'b0;
    case (state)
      WR: begin
        ram_cs = 1'b1;
        ram_we = 1'b1;
      end
      RD, CAP: begin
        ram_cs = 1'b1;
        ram_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

endmodule
